// File: rtl/patient_record_store.sv
// Two-bank circular record store fed by the InformationController write
// strobes. Each strobe's rising edge commits data_in to its bank. Pops have
// one cycle of latency and report empty-bank attempts. Full banks overwrite
// their oldest entry and raise a sticky overflow flag.

// One circular bank: edge-detected write, pop, occupancy and sticky overflow.
module prs_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic              ov_clr,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              strobe_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              wr_ev, pop_ok, full;

    // A strobe held high through reset release fires on the first edge,
    // since the history register comes out of reset at 0.
    assign wr_ev  = strobe & ~strobe_q;
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign pop_ok = pop & ~empty;

    // Next-state pointers, occupancy and overflow; an overflowing write beats ov_clr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (ov_clr) ovf_d = 1'b0;
        if (wr_ev)  wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_ev, pop_ok})
            2'b10: begin
                if (full) begin
                    // Drop the oldest entry to make room.
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    ovf_d    = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b01:   count_d = count_q - CNT_ONE;
            default: ;  // idle, or pop+write cancel out
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            strobe_q <= strobe;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset. When full, a pop and a write hit the same slot;
    // the read port sees the pre-edge value, so the pop still gets the old entry.
    always_ff @(posedge clock) begin
        if (wr_ev) mem_q[wr_ptr_q] <= data_in;
    end

    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// Top: two banks (0 = P, 1 = Q) sharing data_in and one registered read port.
module patient_record_store #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              writeRegP,
    input  logic              writeRegQ,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_req,
    input  logic              rd_sel,
    input  logic              ov_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [ADDR_W:0]   p_count,
    output logic [ADDR_W:0]   q_count,
    output logic              p_overflow,
    output logic              q_overflow
);
    logic [1:0]             strobe, pop, bank_empty, bank_ovf;
    logic [1:0][DATA_W-1:0] bank_head;
    logic [1:0][ADDR_W:0]   bank_cnt;
    logic                   sel_empty;
    logic [DATA_W-1:0]      sel_head;
    logic [DATA_W-1:0]      rd_data_q;
    logic                   rd_valid_q, rd_err_q;

    assign strobe = {writeRegQ, writeRegP};
    assign pop    = {rd_req & rd_sel, rd_req & ~rd_sel};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        prs_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
            .clock    (clock),
            .reset_n  (reset_n),
            .strobe   (strobe[b]),
            .data_in  (data_in),
            .pop      (pop[b]),
            .ov_clr   (ov_clr),
            .head     (bank_head[b]),
            .empty    (bank_empty[b]),
            .count    (bank_cnt[b]),
            .overflow (bank_ovf[b])
        );
    end

    assign sel_empty = bank_empty[rd_sel];
    assign sel_head  = bank_head[rd_sel];

    // Read response register: data+valid on a good pop, err on an empty pop;
    // rd_data holds across errors and idle cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req & ~sel_empty;
            rd_err_q   <= rd_req & sel_empty;
            if (rd_req && !sel_empty) rd_data_q <= sel_head;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign p_count    = bank_cnt[0];
    assign q_count    = bank_cnt[1];
    assign p_overflow = bank_ovf[0];
    assign q_overflow = bank_ovf[1];
endmodule

// File: tb/tb_patient_record_store.sv
// Scoreboard bench for patient_record_store: pops push their expected
// response into a queue, a monitor pops and compares on rd_valid/rd_err.
module tb_patient_record_store;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       writeRegP, writeRegQ;
    logic [7:0] data_in;
    logic       rd_req, rd_sel, ov_clr;
    logic [7:0] rd_data;
    logic       rd_valid, rd_err;
    logic [3:0] p_count, q_count;
    logic       p_overflow, q_overflow;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    patient_record_store dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .writeRegP  (writeRegP),
        .writeRegQ  (writeRegQ),
        .data_in    (data_in),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .ov_clr     (ov_clr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .p_count    (p_count),
        .q_count    (q_count),
        .p_overflow (p_overflow),
        .q_overflow (q_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented read response with the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (rd_valid || rd_err) begin
                n_cmp++;
                if (rd_valid && rd_err) begin
                    n_bad++;
                    $display("FAIL rd_both: rd_valid and rd_err high together");
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_unexpected: valid=%0b err=%0b data=%0h with nothing expected",
                             rd_valid, rd_err, rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rd_err != e.err || rd_data != e.data) begin
                        n_bad++;
                        $display("FAIL rd_resp: got err=%0b data=%0h expected err=%0b data=%0h",
                                 rd_err, rd_data, e.err, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        writeRegP = 1'b0; writeRegQ = 1'b0; rd_req = 1'b0; ov_clr = 1'b0;
        step();
    endtask

    // One active cycle then one idle cycle, so strobes always make fresh edges.
    task automatic op(input bit wp, input bit wq, input logic [7:0] d,
                      input bit rq, input bit rs, input bit oc,
                      input bit ee, input logic [7:0] ed);
        exp_t e;
        writeRegP = wp; writeRegQ = wq; data_in = d;
        rd_req = rq; rd_sel = rs; ov_clr = oc;
        if (rq) begin
            e.err = ee; e.data = ed;
            exp_q.push_back(e);
        end
        step();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        writeRegP = 1'b0; writeRegQ = 1'b0; data_in = 8'h00;
        rd_req = 1'b0; rd_sel = 1'b0; ov_clr = 1'b0;
        #3;
        chk("rst_p_count", p_count, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_p_ovf", p_overflow, 0);
        chk("rst_q_ovf", q_overflow, 0);
        #19 reset_n = 1'b1;

        // Long strobe gives a single write.
        writeRegP = 1'b1; data_in = 8'hFF;
        repeat (5) step();
        chk("hold_p_count", p_count, 1);
        idle();
        op(0, 0, 8'h00, 1, 0, 0, 0, 8'hFF);
        chk("hold_pop_p_count", p_count, 0);

        // Nine writes into P: overflow, oldest dropped.
        for (int i = 1; i <= 9; i++) op(1, 0, 8'(i), 0, 0, 0, 0, 8'h00);
        chk("ovf_p_count", p_count, 8);
        chk("ovf_p_flag", p_overflow, 1);
        // Back-to-back pops, one per cycle.
        for (int i = 2; i <= 9; i++) begin
            exp_t e;
            e.err = 1'b0; e.data = 8'(i);
            exp_q.push_back(e);
            rd_req = 1'b1; rd_sel = 1'b0;
            step();
        end
        idle();
        chk("burst_p_count", p_count, 0);
        op(0, 0, 8'h00, 1, 0, 0, 1, 8'h09);  // empty: err, data held
        chk("err_p_count", p_count, 0);
        chk("ovf_flag_sticky", p_overflow, 1);
        op(0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        chk("ov_clr_p", p_overflow, 0);
        chk("ov_clr_q", q_overflow, 0);

        // Simultaneous P and Q writes.
        op(1, 1, 8'h7F, 0, 0, 0, 0, 8'h00);
        chk("both_p_count", p_count, 1);
        chk("both_q_count", q_count, 1);
        op(0, 0, 8'h00, 1, 1, 0, 0, 8'h7F);
        chk("both_popq_p_count", p_count, 1);
        chk("both_popq_q_count", q_count, 0);
        op(0, 0, 8'h00, 1, 0, 0, 0, 8'h7F);

        // Full Q: pop and write together, no overflow.
        for (int i = 0; i < 8; i++) op(0, 1, 8'h10 + 8'(i), 0, 0, 0, 0, 8'h00);
        chk("qfull_count", q_count, 8);
        op(0, 1, 8'h18, 1, 1, 0, 0, 8'h10);
        chk("qfull_rw_count", q_count, 8);
        chk("qfull_rw_ovf", q_overflow, 0);
        for (int i = 1; i <= 8; i++) op(0, 0, 8'h00, 1, 1, 0, 0, 8'h10 + 8'(i));
        chk("qdrain_count", q_count, 0);

        // Empty Q: pop errors, write still lands, no bypass.
        op(0, 1, 8'h55, 1, 1, 0, 1, 8'h18);
        chk("qempty_rw_count", q_count, 1);
        op(0, 0, 8'h00, 1, 1, 0, 0, 8'h55);

        // Overflowing write with ov_clr: set wins.
        for (int i = 0; i < 8; i++) op(1, 0, 8'h20 + 8'(i), 0, 0, 0, 0, 8'h00);
        op(1, 0, 8'h28, 0, 0, 1, 0, 8'h00);
        chk("setwins_ovf", p_overflow, 1);
        chk("setwins_count", p_count, 8);
        for (int i = 1; i <= 5; i++) op(0, 0, 8'h00, 1, 0, 0, 0, 8'h20 + 8'(i));
        chk("pre_rst_count", p_count, 3);

        // Async reset with a pop pending (no response expected).
        rd_req = 1'b1; rd_sel = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_p_count", p_count, 0);
        chk("midrst_p_ovf", p_overflow, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        rd_req = 1'b0;
        writeRegQ = 1'b1; data_in = 8'h66;
        step();
        #3 reset_n = 1'b1;
        step();
        chk("post_rst_p_count", p_count, 0);
        chk("post_rst_q_count", q_count, 1);  // strobe high at release counts
        idle();
        idle();
        op(0, 0, 8'h00, 1, 1, 0, 0, 8'h66);

        idle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
